// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (1280x1024 @ 60 Hz, 108 MHz pixel clock),
// derived totals and the packed-colour field positions.
package vga_pkg;

  localparam int CNT_W = 11;
  localparam int PCNT_W = 10;
  localparam int COLOR_W = 12;

  localparam int H_VIS_DEF  = 1280;
  localparam int H_FP_DEF   = 48;
  localparam int H_SYNC_DEF = 112;
  localparam int H_BP_DEF   = 248;
  localparam int V_VIS_DEF  = 1024;
  localparam int V_FP_DEF   = 1;
  localparam int V_SYNC_DEF = 3;
  localparam int V_BP_DEF   = 38;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // pixel_color layout is {R, G, B}, four bits each
  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with combinational visible flags and
// sync-window decodes taken straight from the current counter values.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] x_pix,
  output logic [CNT_W-1:0] y_pix,
  output logic             h_visible,
  output logic             v_visible,
  output logic             h_sync_win,
  output logic             v_sync_win,
  output logic             frame_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_end;

  always_comb begin
    line_end  = (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
    x_d       = line_end ? '0 : x_q + ONE;
    y_d       = y_q;
    if (line_end) begin
      y_d = (y_q == V_LAST) ? '0 : y_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_pix      = x_q;
  assign y_pix      = y_q;
  assign h_visible  = (x_q < H_VIS_C);
  assign v_visible  = (y_q < V_VIS_C);
  assign h_sync_win = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign v_sync_win = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

endmodule

// File: rtl/de0_vga.sv
// VGA output stage: two-cycle pipeline from counters to pins, colour gating
// outside the visible area, and a running visible-pixel counter.
module de0_vga
  import vga_pkg::*;
#(
  parameter int H_VIS    = H_VIS_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_VIS    = V_VIS_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] pixel_color,
  output logic [3:0]         VGA_BUS_R,
  output logic [3:0]         VGA_BUS_G,
  output logic [3:0]         VGA_BUS_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [CNT_W-1:0]   X_pix,
  output logic [CNT_W-1:0]   Y_pix,
  output logic               H_visible,
  output logic               V_visible,
  output logic               pixel_clk,
  output logic [PCNT_W-1:0]  pixel_cnt
);

  logic h_sync_win, v_sync_win, frame_end;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk        (clk_50),
    .rst_n      (rst_n),
    .x_pix      (X_pix),
    .y_pix      (Y_pix),
    .h_visible  (H_visible),
    .v_visible  (V_visible),
    .h_sync_win (h_sync_win),
    .v_sync_win (v_sync_win),
    .frame_end  (frame_end)
  );

  assign pixel_clk = clk_50;

  logic               visible;
  logic               visible_q, hs_win_q, vs_win_q;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic [PCNT_W-1:0]  pixel_cnt_q, pixel_cnt_d;

  always_comb begin
    visible = H_visible & V_visible;
    rgb_d   = visible_q ? pixel_color : '0;
    hs_d    = hs_win_q ? SYNC_POL : ~SYNC_POL;
    vs_d    = vs_win_q ? SYNC_POL : ~SYNC_POL;
    // Clearing on the last raster position makes the count read 0 at (0,0).
    pixel_cnt_d = pixel_cnt_q;
    if (frame_end) begin
      pixel_cnt_d = '0;
    end else if (visible) begin
      pixel_cnt_d = pixel_cnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      visible_q   <= 1'b0;
      hs_win_q    <= 1'b0;
      vs_win_q    <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      pixel_cnt_q <= '0;
    end else begin
      visible_q   <= visible;
      hs_win_q    <= h_sync_win;
      vs_win_q    <= v_sync_win;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pixel_cnt_q <= pixel_cnt_d;
    end
  end

  assign VGA_BUS_R = rgb_q[R_HI:R_LO];
  assign VGA_BUS_G = rgb_q[G_HI:G_LO];
  assign VGA_BUS_B = rgb_q[B_HI:B_LO];
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign pixel_cnt = pixel_cnt_q;

endmodule

// File: tb/tb_de0_vga.sv
// Randomised-colour bench for de0_vga on a reduced raster; a raster model
// predicts counters and pins, pin expectations go through a scoreboard queue.
module tb_de0_vga;

  localparam int HV = 64, HF = 4, HS = 8, HB = 12;
  localparam int VV = 20, VF = 1, VS = 3, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk_50 = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pixel_color = 12'h000;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;
  logic [10:0] x_pix, y_pix;
  logic        h_visible, v_visible, pixel_clk;
  logic [9:0]  pixel_cnt;

  de0_vga #(
    .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b1)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .pixel_color (pixel_color),
    .VGA_BUS_R   (vga_r),
    .VGA_BUS_G   (vga_g),
    .VGA_BUS_B   (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .X_pix       (x_pix),
    .Y_pix       (y_pix),
    .H_visible   (h_visible),
    .V_visible   (v_visible),
    .pixel_clk   (pixel_clk),
    .pixel_cnt   (pixel_cnt)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          cyc;
  } pin_t;

  pin_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          in_reset = 1'b1;
  int          cyc = 0;
  logic [11:0] prev_color = 12'h000;

  // Raster model: cycle c after reset release sits at position c of the frame.
  function automatic int px(int c);
    return c % HT;
  endfunction
  function automatic int py(int c);
    return (c / HT) % VT;
  endfunction
  function automatic bit vis(int c);
    return (px(c) < HV) && (py(c) < VV);
  endfunction
  function automatic bit hwin(int c);
    return (px(c) >= HV + HF) && (px(c) < HV + HF + HS);
  endfunction
  function automatic bit vwin(int c);
    return (py(c) >= VV + VF) && (py(c) < VV + VF + VS);
  endfunction
  // Visible pixels strictly before this position in the frame, modulo 1024.
  function automatic int exp_cnt(int c);
    int x, y, n;
    x = px(c);
    y = py(c);
    if (y < VV) n = y * HV + ((x < HV) ? x : HV);
    else        n = VV * HV;
    return n % 1024;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; entered #1 after the edge that starts cycle cyc.
  task automatic step();
    pin_t e;
    chk("x_pix", int'(x_pix), px(cyc));
    chk("y_pix", int'(y_pix), py(cyc));
    chk("h_visible", int'(h_visible), int'(px(cyc) < HV));
    chk("v_visible", int'(v_visible), int'(py(cyc) < VV));
    chk("pixel_cnt", int'(pixel_cnt), exp_cnt(cyc));
    if (cyc < 2) begin
      e.rgb = 12'h000; e.hs = 1'b0; e.vs = 1'b0;
    end else begin
      e.rgb = vis(cyc - 2) ? prev_color : 12'h000;
      e.hs  = hwin(cyc - 2);
      e.vs  = vwin(cyc - 2);
    end
    e.cyc = cyc;
    sb_q.push_back(e);
    pixel_color = ($urandom_range(0, 3) == 0) ? 12'hA5C : 12'($urandom);
    prev_color  = pixel_color;
    @(posedge clk_50);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, int'(x_pix), 0);
    chk({tag, "_y"}, int'(y_pix), 0);
    chk({tag, "_cnt"}, int'(pixel_cnt), 0);
    chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_hs"}, int'(vga_hs), 0);
    chk({tag, "_vs"}, int'(vga_vs), 0);
  endtask

  task automatic release_reset();
    @(posedge clk_50);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    prev_color = 12'h000;
    in_reset = 1'b0;
  endtask

  // Monitor: compares pins against the scoreboard away from the active edge.
  initial begin
    pin_t e;
    forever begin
      @(negedge clk_50);
      if (!in_reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hs !== e.hs || vga_vs !== e.vs) begin
          errors++;
          $display("FAIL pins cyc=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                   e.cyc, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, e.rgb, e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_50);
    #1;
    chk_reset_outputs("por");
    release_reset();
    for (int i = 0; i < 2 * FRAME + 50; i++) step();

    while (!(px(cyc) == 30 && py(cyc) == 10)) step();
    in_reset = 1'b1;
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk_50);
    #1;
    chk_reset_outputs("held");
    release_reset();
    for (int i = 0; i < FRAME + 100; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
